// File: rtl/chip8_sprite_gpu_if.sv
// Memory-side bus of the CHIP-8 sprite engine: a read request/ack channel and a
// single-cycle write strobe into the shared 4096x8 memory.
interface chip8_sprite_gpu_if;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic        mem_read_ack;
    logic        mem_write;
    logic [11:0] mem_write_idx;
    logic [7:0]  mem_write_byte;

    modport master (
        output mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
        input  mem_read_byte, mem_read_ack
    );

    modport slave (
        input  mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
        output mem_read_byte, mem_read_ack
    );
endinterface

// File: rtl/chip8_sprite_gpu.sv
// CHIP-8 sprite engine: XORs a sprite read from memory into the 128x16 framebuffer
// at 0x100..0x1FF, wrapping in both directions, and flags lit pixels it clears.
module chip8_sprite_gpu (
    input  logic        clk,
    input  logic        reset,
    input  logic        draw_i,
    input  logic [11:0] addr_i,
    input  logic [3:0]  lines_i,
    input  logic [7:0]  x_i,
    input  logic [7:0]  y_i,
    output logic        busy_o,
    output logic        collision_o,
    chip8_sprite_gpu_if.master mem
);
    typedef enum logic [2:0] {
        IDLE, FETCH_SPRITE, READ_L, WRITE_L, READ_R, WRITE_R
    } state_t;

    state_t      state_q;
    logic [11:0] addr_q;
    logic [3:0]  lines_q;
    logic [6:0]  x_q;
    logic [3:0]  y_q;
    logic [3:0]  row_cnt_q;
    logic [7:0]  sprite_q;
    logic        first_q;
    logic        busy_q;
    logic        collision_q;
    logic        mem_read_q;
    logic [11:0] rd_idx_q;
    logic        mem_write_q;
    logic [11:0] wr_idx_q;
    logic [7:0]  wr_byte_q;

    logic [15:0] spr_shift;
    logic [3:0]  fb_row;
    logic [3:0]  col_l;
    logic [3:0]  col_r;
    logic [11:0] l_idx;
    logic [11:0] r_idx;
    logic [3:0]  row_next;
    logic        ack_ok;
    logic        unused_bits;

    // High byte is the part landing in the left column, low byte spills into the right one.
    assign spr_shift   = {sprite_q, 8'h00} >> x_q[2:0];
    assign fb_row      = y_q + row_cnt_q;
    assign col_l       = x_q[6:3];
    assign col_r       = col_l + 4'd1;
    assign l_idx       = {4'h1, fb_row, col_l};
    assign r_idx       = {4'h1, fb_row, col_r};
    assign row_next    = row_cnt_q + 4'd1;
    // The first cycle of a read state may see an ack left over from the previous
    // request, so only acks from the second cycle on belong to the current address.
    assign ack_ok      = mem.mem_read_ack && !first_q;
    assign unused_bits = ^{x_i[7], y_i[7:4]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= 12'h000;
            lines_q     <= 4'd0;
            x_q         <= 7'd0;
            y_q         <= 4'd0;
            row_cnt_q   <= 4'd0;
            sprite_q    <= 8'h00;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            collision_q <= 1'b0;
            mem_read_q  <= 1'b0;
            rd_idx_q    <= 12'h000;
            mem_write_q <= 1'b0;
            wr_idx_q    <= 12'h000;
            wr_byte_q   <= 8'h00;
        end else begin
            first_q     <= 1'b0;
            mem_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (draw_i) begin
                        addr_q      <= addr_i;
                        lines_q     <= lines_i;
                        x_q         <= x_i[6:0];
                        y_q         <= y_i[3:0];
                        row_cnt_q   <= 4'd0;
                        busy_q      <= 1'b1;
                        collision_q <= 1'b0;
                        mem_read_q  <= (lines_i != 4'd0);
                        rd_idx_q    <= addr_i;
                        first_q     <= 1'b1;
                        state_q     <= FETCH_SPRITE;
                    end
                end
                FETCH_SPRITE: begin
                    if (row_cnt_q == lines_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (ack_ok) begin
                        sprite_q <= mem.mem_read_byte;
                        rd_idx_q <= l_idx;
                        first_q  <= 1'b1;
                        state_q  <= READ_L;
                    end
                end
                READ_L: begin
                    if (ack_ok) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b1;
                        wr_idx_q    <= l_idx;
                        wr_byte_q   <= mem.mem_read_byte ^ spr_shift[15:8];
                        collision_q <= collision_q | (|(mem.mem_read_byte & spr_shift[15:8]));
                        state_q     <= WRITE_L;
                    end
                end
                READ_R: begin
                    if (ack_ok) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b1;
                        wr_idx_q    <= r_idx;
                        wr_byte_q   <= mem.mem_read_byte ^ spr_shift[7:0];
                        collision_q <= collision_q | (|(mem.mem_read_byte & spr_shift[7:0]));
                        state_q     <= WRITE_R;
                    end
                end
                WRITE_L, WRITE_R: begin
                    if (state_q == WRITE_L && x_q[2:0] != 3'd0) begin
                        mem_read_q <= 1'b1;
                        rd_idx_q   <= r_idx;
                        first_q    <= 1'b1;
                        state_q    <= READ_R;
                    end else begin
                        row_cnt_q <= row_next;
                        if (row_next == lines_q) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            mem_read_q <= 1'b1;
                            rd_idx_q   <= addr_q + {8'h00, row_next};
                            first_q    <= 1'b1;
                            state_q    <= FETCH_SPRITE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o             = busy_q;
    assign collision_o        = collision_q;
    assign mem.mem_read       = mem_read_q;
    assign mem.mem_read_idx   = rd_idx_q;
    assign mem.mem_write      = mem_write_q;
    assign mem.mem_write_idx  = wr_idx_q;
    assign mem.mem_write_byte = wr_byte_q;
endmodule

// File: tb/tb_chip8_sprite_gpu.sv
// Scoreboard bench for chip8_sprite_gpu: directed draws against a 4096x8 memory model
// that acks every sampled read one cycle later.
module tb_chip8_sprite_gpu;
    logic        clk = 1'b0;
    logic        reset;
    logic        draw;
    logic [11:0] addr;
    logic [3:0]  lines;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        busy;
    logic        collision;

    always #5 clk = ~clk;

    chip8_sprite_gpu_if mif ();

    chip8_sprite_gpu dut (
        .clk         (clk),
        .reset       (reset),
        .draw_i      (draw),
        .addr_i      (addr),
        .lines_i     (lines),
        .x_i         (x),
        .y_i         (y),
        .busy_o      (busy),
        .collision_o (collision),
        .mem         (mif)
    );

    logic [7:0]  mem [4096];
    logic        mem_clr;
    logic        pk_en;
    logic [11:0] pk_addr;
    logic [7:0]  pk_data;

    always @(posedge clk) begin
        mif.mem_read_ack  <= mif.mem_read;
        mif.mem_read_byte <= mem[mif.mem_read_idx];
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end else begin
            if (mif.mem_write) mem[mif.mem_write_idx] <= mif.mem_write_byte;
            if (pk_en) mem[pk_addr] <= pk_data;
        end
    end

    typedef struct {
        logic [11:0] idx;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic col;
        int   cycles;
    } done_t;

    wr_t   wq[$];
    done_t dq[$];
    wr_t   mon_w;
    done_t mon_d;
    int    bcnt = 0;
    int    checks = 0;
    int    fails = 0;

    // Monitor: pops expected writes and draw completions as the DUT produces them.
    always @(negedge clk) begin
        if (reset) begin
            bcnt = 0;
        end else begin
            checks++;
            if (mif.mem_read && mif.mem_write) begin
                fails++;
                $display("FAIL rw_overlap: mem_read=1 mem_write=1, required not both");
            end
            if (mif.mem_write) begin
                checks++;
                if (wq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: idx=%03h data=%02h, required no write",
                             mif.mem_write_idx, mif.mem_write_byte);
                end else begin
                    mon_w = wq.pop_front();
                    if (mif.mem_write_idx !== mon_w.idx || mif.mem_write_byte !== mon_w.data) begin
                        fails++;
                        $display("FAIL write: got %03h<=%02h, required %03h<=%02h",
                                 mif.mem_write_idx, mif.mem_write_byte, mon_w.idx, mon_w.data);
                    end else begin
                        $display("write %03h <= %02h ok", mon_w.idx, mon_w.data);
                    end
                end
            end
            if (busy) begin
                bcnt++;
            end else if (bcnt != 0) begin
                checks++;
                if (dq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: busy cycles=%0d, required no draw", bcnt);
                end else begin
                    mon_d = dq.pop_front();
                    if (collision !== mon_d.col || bcnt != mon_d.cycles) begin
                        fails++;
                        $display("FAIL done: collision=%0b cycles=%0d, required collision=%0b cycles=%0d",
                                 collision, bcnt, mon_d.col, mon_d.cycles);
                    end else begin
                        $display("draw done collision=%0b cycles=%0d ok", collision, bcnt);
                    end
                end
                bcnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_addr = a; pk_data = d;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [7:0] d);
        wr_t w;
        w.idx = a; w.data = d;
        wq.push_back(w);
    endtask

    task automatic push_done(input logic c, input int cyc);
        done_t d;
        d.col = c; d.cycles = cyc;
        dq.push_back(d);
    endtask

    task automatic do_draw(input logic [11:0] a, input logic [3:0] l, input logic [7:0] xx, input logic [7:0] yy);
        @(negedge clk);
        draw = 1'b1; addr = a; lines = l; x = xx; y = yy;
        @(negedge clk);
        draw = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1; mem_clr = 1'b1; draw = 1'b0; addr = 12'h000; lines = 4'd0;
        x = 8'd0; y = 8'd0; pk_en = 1'b0; pk_addr = 12'h000; pk_data = 8'h00;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_collision", {31'd0, collision}, 32'd0);
        chk("rst_mem_read", {31'd0, mif.mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mif.mem_write}, 32'd0);
        chk("rst_read_idx", {20'd0, mif.mem_read_idx}, 32'd0);
        chk("rst_write_idx", {20'd0, mif.mem_write_idx}, 32'd0);
        chk("rst_write_byte", {24'd0, mif.mem_write_byte}, 32'd0);
        reset = 1'b0;

        poke(12'h042, 8'hFF); poke(12'h043, 8'hC3); poke(12'h044, 8'hC3);
        poke(12'h045, 8'hC3); poke(12'h046, 8'hFF);
        poke(12'h050, 8'hFF); poke(12'h060, 8'hFF); poke(12'h061, 8'hFF);
        poke(12'h070, 8'h01); poke(12'h071, 8'h02); poke(12'h072, 8'h04);
        poke(12'h073, 8'h08); poke(12'h074, 8'h10);

        // Aligned draw onto a clear screen
        push_wr(12'h100, 8'hFF); push_wr(12'h110, 8'hC3); push_wr(12'h120, 8'hC3);
        push_wr(12'h130, 8'hC3); push_wr(12'h140, 8'hFF);
        push_done(1'b0, 25);
        do_draw(12'h042, 4'd5, 8'd0, 8'd0);
        wait_idle("aligned_timeout");
        chk("aligned_100", {24'd0, mem[12'h100]}, 32'hFF);
        chk("aligned_120", {24'd0, mem[12'h120]}, 32'hC3);
        chk("aligned_140", {24'd0, mem[12'h140]}, 32'hFF);
        chk("aligned_collision", {31'd0, collision}, 32'd0);

        // Same sprite again erases it and reports a collision
        push_wr(12'h100, 8'h00); push_wr(12'h110, 8'h00); push_wr(12'h120, 8'h00);
        push_wr(12'h130, 8'h00); push_wr(12'h140, 8'h00);
        push_done(1'b1, 25);
        do_draw(12'h042, 4'd5, 8'd0, 8'd0);
        wait_idle("redraw_timeout");
        chk("redraw_110", {24'd0, mem[12'h110]}, 32'h00);
        chk("redraw_140", {24'd0, mem[12'h140]}, 32'h00);
        chk("redraw_collision", {31'd0, collision}, 32'd1);

        // lines=0: single busy cycle, no memory traffic, collision cleared
        push_done(1'b0, 1);
        do_draw(12'h042, 4'd0, 8'd0, 8'd0);
        chk("zero_busy_high", {31'd0, busy}, 32'd1);
        chk("zero_no_read", {31'd0, mif.mem_read}, 32'd0);
        @(negedge clk);
        chk("zero_busy_low", {31'd0, busy}, 32'd0);
        chk("zero_collision", {31'd0, collision}, 32'd0);

        // Unaligned draw spans two bytes
        push_wr(12'h120, 8'h0F); push_wr(12'h121, 8'hF0);
        push_done(1'b0, 8);
        do_draw(12'h050, 4'd1, 8'd4, 8'd2);
        wait_idle("unaligned_timeout");
        chk("unaligned_120", {24'd0, mem[12'h120]}, 32'h0F);
        chk("unaligned_121", {24'd0, mem[12'h121]}, 32'hF0);

        // Wrap both ways; a draw pulse mid-draw must be ignored
        push_wr(12'h1FF, 8'h0F); push_wr(12'h1F0, 8'hF0);
        push_wr(12'h10F, 8'h0F); push_wr(12'h100, 8'hF0);
        push_done(1'b0, 16);
        do_draw(12'h060, 4'd2, 8'd124, 8'd15);
        repeat (3) @(negedge clk);
        do_draw(12'h042, 4'd5, 8'd0, 8'd0);
        wait_idle("wrap_timeout");
        chk("wrap_1ff", {24'd0, mem[12'h1FF]}, 32'h0F);
        chk("wrap_1f0", {24'd0, mem[12'h1F0]}, 32'hF0);
        chk("wrap_10f", {24'd0, mem[12'h10F]}, 32'h0F);
        chk("wrap_100", {24'd0, mem[12'h100]}, 32'hF0);

        // Reset during the third row aborts the draw
        push_wr(12'h141, 8'h01); push_wr(12'h151, 8'h02);
        do_draw(12'h070, 4'd5, 8'd8, 8'd4);
        n = 0;
        while (!(mif.mem_read && mif.mem_read_idx == 12'h072) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_third_row_seen", {31'd0, mif.mem_read}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mem_read", {31'd0, mif.mem_read}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_pending_writes", wq.size(), 32'd0);
        chk("abort_161", {24'd0, mem[12'h161]}, 32'h00);
        chk("abort_151", {24'd0, mem[12'h151]}, 32'h02);

        // Fresh draw after the abort
        push_wr(12'h141, 8'h00); push_wr(12'h151, 8'h00); push_wr(12'h161, 8'h04);
        push_wr(12'h171, 8'h08); push_wr(12'h181, 8'h10);
        push_done(1'b1, 25);
        do_draw(12'h070, 4'd5, 8'd8, 8'd4);
        wait_idle("fresh_timeout");
        chk("fresh_181", {24'd0, mem[12'h181]}, 32'h10);
        chk("fresh_collision", {31'd0, collision}, 32'd1);

        chk("writes_drained", wq.size(), 32'd0);
        chk("dones_drained", dq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/chip8_sprite_gpu.md
# chip8_sprite_gpu

Sprite-drawing engine of the CHIP-8 core (module name `gpu`). On a draw request it reads a sprite from main memory, XORs it into the framebuffer held in the same memory, and reports whether any lit pixel was cleared. It sits between the CPU's draw instruction and the shared memory, and uses the memory's read/ack and write ports.

## Interface
- No parameters.
- Framebuffer: base 0x100, 256 bytes, 128×16 pixels, 16 bytes per row, MSB = leftmost pixel.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- draw  in  1  start pulse; sampled only when busy=0.
- addr  in  12  sprite start address in memory.
- lines  in  4  sprite height in rows (bytes), 0–15.
- x  in  8  pixel column; only x[6:0] is used.
- y  in  8  pixel row; only y[3:0] is used.
- busy  out  1  high while a draw is in progress.
- collision  out  1  a sprite bit hit an already-lit pixel during the last draw.
- mem_read  out  1  read request strobe.
- mem_read_idx  out  12  read address.
- mem_read_byte  in  8  read data, valid when mem_read_ack=1.
- mem_read_ack  in  1  read data valid.
- mem_write  out  1  write strobe, one cycle per byte.
- mem_write_idx  out  12  write address.
- mem_write_byte  out  8  write data.

## Operation
- Byte address of pixel (px,py) = 0x100 + py[3:0]*16 + px[6:3].
- On draw with busy=0: latch addr, lines, x, y; clear collision; set row counter i=0.
- For each row i < lines:
  - Read the sprite byte S at (addr+i) mod 4096.
  - Let s = x[2:0], row = (y+i) mod 16, col = x[6:3].
  - Left byte L at column col: read it, write L ^ (S >> s); collision |= |(L & (S >> s)).
  - If s≠0, right byte R at column (col+1) mod 16 of the same row: read it, write R ^ (S << (8−s))[7:0]; collision |= the matching AND term.
  - Wrap horizontally within the row and vertically within 16 rows. Never touch bytes outside 0x100–0x1FF.
- States: IDLE → FETCH_SPRITE → READ_L → WRITE_L → (s≠0: READ_R → WRITE_R) → next row or IDLE. Each READ state holds mem_read and mem_read_idx until the cycle mem_read_ack=1, then captures the data.
- lines=0: no memory access; busy is high for exactly one cycle; collision=0.
- mem_read and mem_write are never high in the same cycle.
- Reset outputs: busy=0, collision=0, mem_read=0, mem_write=0, mem_read_idx=0, mem_write_idx=0, mem_write_byte=0; state IDLE.
- Reset mid-draw aborts immediately. No further reads or writes are issued, and bytes already written stay written.

## Timing
- busy rises on the clk edge that samples draw=1 with busy=0. It falls on the edge after the last write of the final row.
- draw while busy=1 is ignored.
- collision is updated while drawing. It is final when busy falls and holds until the next accepted draw.
- Memory companion (`mem`): 4096×8, asserts mem_read_ack with mem_read_byte one cycle after a sampled mem_read; a write lands on the edge where mem_write=1.
- With 1-cycle ack, per row: 2 cycles sprite fetch, 2 cycles left read, 1 cycle left write. Add 3 cycles for the right byte when s≠0. The GPU must tolerate longer ack latency.
- The GPU does not start another read until the previous ack has been received.

## Test plan
- Aligned draw: mem[0x42..0x46] = FF,C3,C3,C3,FF on a cleared screen; draw addr=0x42, lines=5, x=0, y=0. Required: mem[0x100]=FF, [0x110]=C3, [0x120]=C3, [0x130]=C3, [0x140]=FF, collision=0, and busy falls within 100 cycles.
- Redraw the identical sprite: all five bytes return to 00, collision=1.
- Unaligned: sprite byte FF, lines=1, x=4, y=2. Required: mem[0x120]=0F, mem[0x121]=F0, collision=0.
- Wrap: sprite byte FF, lines=2, x=124, y=15. Required: mem[0x1FF]=0F, mem[0x1F0]=F0, mem[0x10F]=0F, mem[0x100]=F0.
- lines=0: busy is high for one cycle, no mem_write, and collision=0.
- Assert reset during the third row of a 5-line draw. Required: busy=0 on the next cycle, no further writes, and a fresh draw then completes normally.
